// File: rtl/noise_acq_ctrl_if.sv
// Bundle of everything noise_acq_ctrl exchanges with the host command
// registers, the noiseacq block and the downstream DSP/host stream.
// The controller uses the master view. The environment uses the slave view.
interface noise_acq_ctrl_if #(
  parameter int DIV_W  = 10,
  parameter int CNT_W  = 12,
  parameter int DATA_W = 16
);
  logic              start;
  logic              abort;
  logic [DIV_W-1:0]  cfg_divnum;
  logic [CNT_W-1:0]  cfg_acqnum;
  logic              n_acqclk;
  logic [DATA_W-1:0] n_dataout;
  logic              rd_ready;
  logic              n_load;
  logic              n_en;
  logic [DIV_W-1:0]  n_divnum;
  logic [CNT_W-1:0]  n_acqnum;
  logic              n_rd_rst;
  logic              n_rd_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              cfg_err;

  modport master (
    input  start, abort, cfg_divnum, cfg_acqnum, n_acqclk, n_dataout, rd_ready,
    output n_load, n_en, n_divnum, n_acqnum, n_rd_rst, n_rd_en,
           out_data, out_valid, busy, done, timeout, cfg_err
  );

  modport slave (
    output start, abort, cfg_divnum, cfg_acqnum, n_acqclk, n_dataout, rd_ready,
    input  n_load, n_en, n_divnum, n_acqnum, n_rd_rst, n_rd_en,
           out_data, out_valid, busy, done, timeout, cfg_err
  );
endinterface

// File: rtl/noise_acq_ctrl.sv
// Sequencer for the noiseacq acquisition block.
// It latches a request, loads and enables noiseacq, and counts sample strobes
// until the requested number of samples is reached, or until the timeout
// guard fires. It then flushes, resets the read side and drains the FIFO
// into a ready/valid stream. Everything runs on clk_sys.
module noise_acq_ctrl #(
  parameter int DIV_W     = 10,
  parameter int CNT_W     = 12,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int FLUSH_CYC = 4,
  parameter int TMO_CYC   = 1048576
) (
  input  logic             clk_sys,
  input  logic             reset,
  noise_acq_ctrl_if.master bus
);

  localparam int TMO_W = 24;
  localparam int PH_W  = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) + 1 : 2;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ARM, S_ACQ, S_FLUSH, S_RDRST, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  divnum_q;
  logic [CNT_W-1:0]  acqnum_q;
  logic [CNT_W-1:0]  sample_cnt;
  logic [CNT_W-1:0]  issued_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [PH_W-1:0]   phase_cnt;
  logic              acq_prev;
  logic [RD_LAT-1:0] vld_pipe;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              timeout_q;
  logic              cfg_err_q;

  logic acq_rise, cnt_hit, tmo_hit, tmo_fire, cfg_bad, abort_hit, rd_en;

  // Next-state decode. A sample-count match beats the timeout. Abort beats everything.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    abort_hit = bus.abort && (state_q != S_IDLE);
    cfg_bad   = (bus.cfg_divnum == '0) || (bus.cfg_acqnum == '0);
    acq_rise  = bus.n_acqclk && !acq_prev;
    cnt_hit   = acq_rise && ((sample_cnt + CNT_W'(1)) == acqnum_q);
    tmo_hit   = (tmo_cnt == TMO_W'(TMO_CYC - 1));
    tmo_fire  = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = cfg_bad ? S_DONE : S_LOAD;
      S_LOAD:  state_d = S_ARM;
      S_ARM:   state_d = S_ACQ;
      S_ACQ: begin
        if (cnt_hit) begin
          state_d = S_FLUSH;
        end else if (tmo_hit) begin
          state_d  = S_DONE;
          tmo_fire = !abort_hit;
        end
      end
      S_FLUSH: if (phase_cnt == PH_W'(FLUSH_CYC - 1)) state_d = S_RDRST;
      S_RDRST: if (phase_cnt == PH_W'(1)) state_d = S_READ;
      S_READ: begin
        rd_en = bus.rd_ready && (issued_cnt < acqnum_q);
        if (issued_cnt == acqnum_q) state_d = S_DRAIN;
      end
      S_DRAIN: if (vld_pipe == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Latch config, run the sample/timeout/issue/phase counters, keep sticky flags
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      divnum_q   <= '0;
      acqnum_q   <= '0;
      sample_cnt <= '0;
      issued_cnt <= '0;
      tmo_cnt    <= '0;
      phase_cnt  <= '0;
      acq_prev   <= 1'b0;
      timeout_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && bus.start) begin
        divnum_q  <= bus.cfg_divnum;
        acqnum_q  <= bus.cfg_acqnum;
        timeout_q <= 1'b0;
        cfg_err_q <= cfg_bad;
      end
      if (state_q == S_ARM) begin
        sample_cnt <= '0;
        issued_cnt <= '0;
        tmo_cnt    <= '0;
        acq_prev   <= 1'b0;
      end
      if (state_q == S_ACQ) begin
        acq_prev <= bus.n_acqclk;
        tmo_cnt  <= tmo_cnt + TMO_W'(1);
        if (acq_rise) sample_cnt <= sample_cnt + CNT_W'(1);
      end
      if (tmo_fire) timeout_q <= 1'b1;
      if (rd_en) issued_cnt <= issued_cnt + CNT_W'(1);
      if (state_d != state_q)
        phase_cnt <= '0;
      else if (state_q == S_FLUSH || state_q == S_RDRST)
        phase_cnt <= phase_cnt + PH_W'(1);
    end
  end

  // Read pipeline: delay the read strobe by RD_LAT, then register the word alongside it
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vld_pipe    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (abort_hit) begin
      vld_pipe    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      vld_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      out_valid_q <= vld_pipe[RD_LAT-1];
      if (vld_pipe[RD_LAT-1]) out_data_q <= bus.n_dataout;
    end
  end

  assign bus.n_load    = (state_q == S_LOAD);
  assign bus.n_en      = (state_q == S_ACQ);
  assign bus.n_rd_rst  = (state_q != S_RDRST);
  assign bus.n_rd_en   = rd_en;
  assign bus.n_divnum  = divnum_q;
  assign bus.n_acqnum  = acqnum_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.timeout   = timeout_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_noise_acq_ctrl.sv
// Testbench for noise_acq_ctrl.
// Two instances share the same stimulus: one uses the full timeout and the
// other a 64-cycle timeout. A per-cycle monitor watches whichever one is
// selected. A small noiseacq responder injects random FIFO words.
module tb_noise_acq_ctrl;
  localparam int DIV_W     = 10;
  localparam int CNT_W     = 12;
  localparam int DATA_W    = 16;
  localparam int TMO_SHORT = 64;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              start, abort, n_acqclk, rd_ready;
  logic [DIV_W-1:0]  cfg_divnum;
  logic [CNT_W-1:0]  cfg_acqnum;
  logic [DATA_W-1:0] n_dataout = '0;
  logic              sel_tmo;
  int vectors = 0;
  int miscompares = 0;

  noise_acq_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DATA_W(DATA_W)) mbus ();
  noise_acq_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DATA_W(DATA_W)) tbus ();

  assign mbus.start = start;       assign tbus.start = start;
  assign mbus.abort = abort;       assign tbus.abort = abort;
  assign mbus.cfg_divnum = cfg_divnum; assign tbus.cfg_divnum = cfg_divnum;
  assign mbus.cfg_acqnum = cfg_acqnum; assign tbus.cfg_acqnum = cfg_acqnum;
  assign mbus.n_acqclk = n_acqclk; assign tbus.n_acqclk = n_acqclk;
  assign mbus.n_dataout = n_dataout; assign tbus.n_dataout = n_dataout;
  assign mbus.rd_ready = rd_ready; assign tbus.rd_ready = rd_ready;

  noise_acq_ctrl dut (.clk_sys(clk_sys), .reset(reset), .bus(mbus));
  noise_acq_ctrl #(.TMO_CYC(TMO_SHORT)) dut_tmo (.clk_sys(clk_sys), .reset(reset), .bus(tbus));

  always #5 clk_sys = ~clk_sys;

  logic              m_load, m_en, m_rd_rst, m_rd_en, m_valid, m_busy, m_done, m_timeout, m_cfg_err;
  logic [DATA_W-1:0] m_data;
  logic [DIV_W-1:0]  m_divnum;
  logic [CNT_W-1:0]  m_acqnum;
  assign m_load    = sel_tmo ? tbus.n_load    : mbus.n_load;
  assign m_en      = sel_tmo ? tbus.n_en      : mbus.n_en;
  assign m_rd_rst  = sel_tmo ? tbus.n_rd_rst  : mbus.n_rd_rst;
  assign m_rd_en   = sel_tmo ? tbus.n_rd_en   : mbus.n_rd_en;
  assign m_valid   = sel_tmo ? tbus.out_valid : mbus.out_valid;
  assign m_data    = sel_tmo ? tbus.out_data  : mbus.out_data;
  assign m_busy    = sel_tmo ? tbus.busy      : mbus.busy;
  assign m_done    = sel_tmo ? tbus.done      : mbus.done;
  assign m_timeout = sel_tmo ? tbus.timeout   : mbus.timeout;
  assign m_cfg_err = sel_tmo ? tbus.cfg_err   : mbus.cfg_err;
  assign m_divnum  = sel_tmo ? tbus.n_divnum  : mbus.n_divnum;
  assign m_acqnum  = sel_tmo ? tbus.n_acqnum  : mbus.n_acqnum;

  // Per-cycle event monitor, sampled mid-cycle
  int cyc = 0, load_cyc = 0, en_cyc = 0, rises_en = 0, last_rise_cyc = 0, en_fall_cyc = 0;
  int rdrst_cyc = 0, rd_en_cnt = 0, rd_noready = 0, done_cnt = 0, done_cyc = 0;
  int last_valid_cyc = 0, start_cyc = 0;
  logic prev_acq = 1'b0, prev_en = 1'b0;
  logic [DATA_W-1:0] out_q[$];
  logic [DATA_W-1:0] inj_q[$];
  logic [DATA_W-1:0] resp_word;

  always @(negedge clk_sys) begin
    cyc++;
    if (m_load) load_cyc++;
    if (m_en) en_cyc++;
    if (m_en && n_acqclk && !prev_acq) begin rises_en++; last_rise_cyc = cyc; end
    if (prev_en && !m_en) en_fall_cyc = cyc;
    if (!m_rd_rst) rdrst_cyc++;
    if (m_rd_en) rd_en_cnt++;
    if (m_rd_en && !rd_ready) rd_noready++;
    if (m_valid) begin out_q.push_back(m_data); last_valid_cyc = cyc; end
    if (m_done) begin done_cnt++; done_cyc = cyc; end
    if (start && !m_busy && !reset) start_cyc = cyc;
    prev_acq = n_acqclk;
    prev_en  = m_en;
  end

  // noiseacq FIFO model: a read strobe yields a fresh random word one cycle later
  always @(posedge clk_sys) begin
    if (m_rd_en) begin
      resp_word = DATA_W'($urandom);
      inj_q.push_back(resp_word);
      #1 n_dataout = resp_word;
    end
  end

  int acq_half = 0, ready_mode = 0, run_cyc = 0;

  task automatic tick();
    @(posedge clk_sys); #1;
    run_cyc++;
    start = 1'b0;
    abort = 1'b0;
    if (acq_half == 0) n_acqclk = 1'b0;
    else if (run_cyc >= 4 && (run_cyc % acq_half) == 0) n_acqclk = ~n_acqclk;
    case (ready_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = ~rd_ready;
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic apply_reset();
    tick(); reset = 1'b1;
    tick(); tick(); reset = 1'b0;
    tick();
  endtask

  task automatic launch(input int div, input int acq, input int half, input int rmode, input bit with_abort);
    tick();
    acq_half = half; ready_mode = rmode; run_cyc = 0; n_acqclk = 1'b0;
    cfg_divnum = DIV_W'(div); cfg_acqnum = CNT_W'(acq);
    start = 1'b1; abort = with_abort;
  endtask

  // Full run against the reference rules: counts, ordering and in-order data
  task automatic run_check(input string name, input int div, input int acq, input int half,
                           input int rmode, input bit with_abort);
    int b_load, b_en, b_rises, b_rdrst, b_rden, b_nordy, b_done, b_out, b_inj, n, nbad;
    bit exp_err;
    exp_err = (div == 0) || (acq == 0);
    b_load = load_cyc; b_en = en_cyc; b_rises = rises_en; b_rdrst = rdrst_cyc;
    b_rden = rd_en_cnt; b_nordy = rd_noready; b_done = done_cnt;
    b_out = out_q.size(); b_inj = inj_q.size();
    launch(div, acq, half, rmode, with_abort);
    n = 0;
    while (done_cnt == b_done && n < 2000) begin tick(); n++; end
    repeat (3) tick();
    vectors++; if (done_cnt - b_done !== 1) begin miscompares++;
      $display("[TB] FAIL %s done_pulses got=%0d want=1", name, done_cnt - b_done); end
    vectors++; if (m_cfg_err !== exp_err) begin miscompares++;
      $display("[TB] FAIL %s cfg_err got=%0b want=%0b", name, m_cfg_err, exp_err); end
    vectors++; if (m_timeout !== 1'b0) begin miscompares++;
      $display("[TB] FAIL %s timeout got=%0b want=0", name, m_timeout); end
    vectors++; if (m_divnum !== DIV_W'(div) || m_acqnum !== CNT_W'(acq)) begin miscompares++;
      $display("[TB] FAIL %s latched_cfg got=%0d/%0d want=%0d/%0d", name, m_divnum, m_acqnum, div, acq); end
    vectors++; if (m_busy !== 1'b0) begin miscompares++;
      $display("[TB] FAIL %s busy_after got=%0b want=0", name, m_busy); end
    if (exp_err) begin
      vectors++; if (load_cyc - b_load !== 0 || en_cyc - b_en !== 0) begin miscompares++;
        $display("[TB] FAIL %s no_load_en got load=%0d en=%0d want 0/0", name, load_cyc - b_load, en_cyc - b_en); end
      vectors++; if (done_cyc - start_cyc > 2 || done_cyc - start_cyc < 1) begin miscompares++;
        $display("[TB] FAIL %s done_latency got=%0d want 1..2", name, done_cyc - start_cyc); end
    end else begin
      vectors++; if (load_cyc - b_load !== 1) begin miscompares++;
        $display("[TB] FAIL %s load_width got=%0d want=1", name, load_cyc - b_load); end
      vectors++; if (rises_en - b_rises !== acq) begin miscompares++;
        $display("[TB] FAIL %s strobes_while_en got=%0d want=%0d", name, rises_en - b_rises, acq); end
      vectors++; if (en_fall_cyc !== last_rise_cyc + 1) begin miscompares++;
        $display("[TB] FAIL %s en_drop got=%0d want=%0d", name, en_fall_cyc, last_rise_cyc + 1); end
      vectors++; if (rdrst_cyc - b_rdrst !== 2) begin miscompares++;
        $display("[TB] FAIL %s rd_rst_low got=%0d want=2", name, rdrst_cyc - b_rdrst); end
      vectors++; if (rd_en_cnt - b_rden !== acq) begin miscompares++;
        $display("[TB] FAIL %s rd_en_count got=%0d want=%0d", name, rd_en_cnt - b_rden, acq); end
      vectors++; if (rd_noready - b_nordy !== 0) begin miscompares++;
        $display("[TB] FAIL %s rd_en_without_ready got=%0d want=0", name, rd_noready - b_nordy); end
      vectors++; if (out_q.size() - b_out !== acq) begin miscompares++;
        $display("[TB] FAIL %s words_out got=%0d want=%0d", name, out_q.size() - b_out, acq); end
      nbad = 0;
      for (int i = 0; i < acq; i++)
        if (b_out + i >= out_q.size() || b_inj + i >= inj_q.size() || out_q[b_out + i] !== inj_q[b_inj + i])
          nbad++;
      vectors++; if (nbad != 0) begin miscompares++;
        $display("[TB] FAIL %s word_order got=%0d bad words want=0", name, nbad); end
      vectors++; if (done_cyc <= last_valid_cyc) begin miscompares++;
        $display("[TB] FAIL %s done_after_last_word got done=%0d last=%0d", name, done_cyc, last_valid_cyc); end
    end
  endtask

  task automatic test_reset();
    logic [46:0] obs, expv;
    apply_reset();
    obs  = {m_load, m_en, m_rd_en, m_rd_rst, m_divnum, m_acqnum, m_valid, m_data,
            m_busy, m_done, m_timeout, m_cfg_err};
    expv = {3'b000, 1'b1, 43'd0};
    vectors++; if (obs !== expv) begin miscompares++;
      $display("[TB] FAIL reset_values got=%h want=%h", obs, expv); end
  endtask

  task automatic test_basic();
    run_check("basic", 4, 8, 10, 0, 1'b0);
  endtask

  task automatic test_ready_toggle();
    run_check("ready_toggle", 3, 5, 4, 1, 1'b0);
  endtask

  task automatic test_timeout();
    int b_en, b_rden, b_done, b_rdrst, n;
    sel_tmo = 1'b1;
    b_en = en_cyc; b_rden = rd_en_cnt; b_done = done_cnt; b_rdrst = rdrst_cyc;
    launch(2, 3, 0, 0, 1'b0);
    n = 0;
    while (done_cnt == b_done && n < 500) begin tick(); n++; end
    repeat (3) tick();
    vectors++; if (en_cyc - b_en !== TMO_SHORT) begin miscompares++;
      $display("[TB] FAIL timeout en_cycles got=%0d want=%0d", en_cyc - b_en, TMO_SHORT); end
    vectors++; if (m_timeout !== 1'b1) begin miscompares++;
      $display("[TB] FAIL timeout flag got=%0b want=1", m_timeout); end
    vectors++; if (done_cnt - b_done !== 1) begin miscompares++;
      $display("[TB] FAIL timeout done_pulses got=%0d want=1", done_cnt - b_done); end
    vectors++; if (rd_en_cnt - b_rden !== 0 || rdrst_cyc - b_rdrst !== 0) begin miscompares++;
      $display("[TB] FAIL timeout no_readout got rd=%0d rst=%0d want 0/0", rd_en_cnt - b_rden, rdrst_cyc - b_rdrst); end
    run_check("timeout_clear", 2, 2, 3, 0, 1'b0);
    sel_tmo = 1'b0;
    apply_reset();
  endtask

  task automatic test_cfg_err();
    run_check("acqnum_zero", 5, 0, 3, 0, 1'b0);
    run_check("divnum_zero", 0, 4, 3, 0, 1'b0);
  endtask

  task automatic test_abort();
    int b_rises, b_rden, b_done, n;
    b_rises = rises_en; b_done = done_cnt;
    launch(3, 8, 3, 0, 1'b0);
    n = 0;
    while (rises_en - b_rises < 2 && n < 300) begin tick(); n++; end
    abort = 1'b1;
    tick();
    vectors++; if ({m_en, m_rd_en, m_busy} !== 3'b000) begin miscompares++;
      $display("[TB] FAIL abort_acq en/rd_en/busy got=%b want=000", {m_en, m_rd_en, m_busy}); end
    repeat (5) tick();
    vectors++; if (done_cnt - b_done !== 0) begin miscompares++;
      $display("[TB] FAIL abort_acq done_pulses got=%0d want=0", done_cnt - b_done); end
    b_rden = rd_en_cnt; b_done = done_cnt;
    launch(4, 6, 2, 0, 1'b0);
    n = 0;
    while (rd_en_cnt - b_rden < 1 && n < 300) begin tick(); n++; end
    abort = 1'b1;
    tick();
    vectors++; if ({m_en, m_rd_en, m_busy, m_valid} !== 4'b0000) begin miscompares++;
      $display("[TB] FAIL abort_read en/rd_en/busy/valid got=%b want=0000", {m_en, m_rd_en, m_busy, m_valid}); end
    repeat (5) tick();
    vectors++; if (done_cnt - b_done !== 0) begin miscompares++;
      $display("[TB] FAIL abort_read done_pulses got=%0d want=0", done_cnt - b_done); end
    run_check("after_abort", 7, 4, 2, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int b_rden, n;
    logic [46:0] obs, expv;
    b_rden = rd_en_cnt;
    launch(5, 6, 2, 1, 1'b0);
    n = 0;
    while (rd_en_cnt - b_rden < 1 && n < 300) begin tick(); n++; end
    cfg_divnum = DIV_W'(9); cfg_acqnum = CNT_W'(2); start = 1'b1;
    tick();
    vectors++; if (m_divnum !== DIV_W'(5) || m_acqnum !== CNT_W'(6)) begin miscompares++;
      $display("[TB] FAIL busy_start latched got=%0d/%0d want=5/6", m_divnum, m_acqnum); end
    reset = 1'b1;
    tick();
    obs  = {m_load, m_en, m_rd_en, m_rd_rst, m_divnum, m_acqnum, m_valid, m_data,
            m_busy, m_done, m_timeout, m_cfg_err};
    expv = {3'b000, 1'b1, 43'd0};
    vectors++; if (obs !== expv) begin miscompares++;
      $display("[TB] FAIL mid_reset_values got=%h want=%h", obs, expv); end
    reset = 1'b0;
    tick();
    run_check("after_reset", 6, 3, 2, 0, 1'b0);
  endtask

  task automatic test_random();
    int div, acq;
    for (int r = 0; r < 6; r++) begin
      div = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 1023));
      acq = int'($urandom_range(0, 7));
      run_check($sformatf("random%0d", r), div, acq, int'($urandom_range(1, 6)), 2,
                1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; n_acqclk = 1'b0; rd_ready = 1'b1;
    cfg_divnum = '0; cfg_acqnum = '0; sel_tmo = 1'b0;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_timeout();
    test_cfg_err();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hang guard
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/noise_acq_ctrl.md
Name: noise_acq_ctrl

Overview:
Sequencer for the noiseacq acquisition block.
- Latches a noise-acquisition request (clock divider, sample count) and drives the load pulse, acquisition enable and read-FIFO reset of noiseacq.
- Counts n_acqclk sample strobes and stops acquisition after the requested number of samples, with a timeout guard.
- Drains the acquired words through a ready/valid stream to the downstream DSP/host interface.
- Sits between the host command register file and noiseacq, all on clk_sys (noiseacq n_rdclk is tied to clk_sys).

Parameters:
DIV_W, 10, width of divider value (n_divnum)
CNT_W, 12, width of sample count (n_acqnum)
DATA_W, 16, width of noiseacq n_dataout and out_data
RD_LAT, 1, clk_sys cycles from n_rd_en high to valid n_dataout (1..4)
FLUSH_CYC, 4, idle cycles after n_en drops before readout starts
TMO_CYC, 1048576, max clk_sys cycles allowed in ACQ (24-bit counter)

Ports:
clk_sys  in  1  system clock; all logic rising-edge
reset  in  1  synchronous active-high reset
start  in  1  one-cycle request; honoured only in IDLE
abort  in  1  one-cycle abort; honoured in any non-IDLE state
cfg_divnum  in  DIV_W  divider for this run
cfg_acqnum  in  CNT_W  samples for this run
n_acqclk  in  1  sample strobe from noiseacq
n_dataout  in  DATA_W  FIFO read data from noiseacq
rd_ready  in  1  downstream can accept a word this cycle
n_load  out  1  one-cycle config load strobe to noiseacq
n_en  out  1  acquisition enable to noiseacq
n_divnum  out  DIV_W  latched divider to noiseacq
n_acqnum  out  CNT_W  latched count to noiseacq
n_rd_rst  out  1  noiseacq read-side reset, active-low
n_rd_en  out  1  FIFO read enable to noiseacq
out_data  out  DATA_W  word to downstream
out_valid  out  1  out_data valid
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
timeout  out  1  sticky; set on ACQ timeout, cleared on next accepted start
cfg_err  out  1  sticky; set on rejected config, cleared on next accepted start

Behaviour:
- Reset values: n_load=0, n_en=0, n_rd_en=0, n_rd_rst=1, n_divnum=0, n_acqnum=0, out_valid=0, out_data=0, busy=0, done=0, timeout=0, cfg_err=0. State=IDLE, all counters=0. Reset mid-run takes effect on the next edge.
- State machine: IDLE -> LOAD -> ARM -> ACQ -> FLUSH -> RDRST -> READ -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On start, latch cfg_* into n_divnum/n_acqnum and clear timeout/cfg_err.
  - If cfg_divnum==0 or cfg_acqnum==0: set cfg_err and go to DONE. No n_load or n_en activity in this case.
  - Otherwise go to LOAD.
- LOAD: n_load=1 for exactly 1 cycle. n_divnum/n_acqnum stay stable from latch until the next accepted start.
- ARM: 1 cycle; clear sample counter, timeout counter and edge register.
- ACQ:
  - n_en=1 from the edge entering ACQ.
  - A rising edge is registered n_acqclk prev=0, cur=1. Each rising edge increments the sample counter.
  - When the counter reaches n_acqnum: n_en=0 next cycle, go to FLUSH.
  - If the timeout counter reaches TMO_CYC-1 first: n_en=0, set timeout, go to DONE with no readout.
- FLUSH: n_en=0, hold FLUSH_CYC cycles.
- RDRST: n_rd_rst=0 for 2 cycles, then 1.
- READ:
  - n_rd_en = rd_ready AND issued<n_acqnum. Issued-word counter increments on each n_rd_en.
  - When issued==n_acqnum, go to DRAIN.
- Read pipeline: n_rd_en is delayed RD_LAT cycles to form out_valid. out_data = n_dataout, registered on the same delayed strobe. A word presented with out_valid is considered consumed; back-pressure acts only on issue via rd_ready.
- DRAIN: wait until the RD_LAT delay line is empty, then go to DONE.
- DONE: done=1 for 1 cycle, busy=0 on the following cycle, state returns to IDLE.
- abort (non-IDLE states): next edge forces n_en=0, n_rd_en=0, n_load=0, n_rd_rst=1, flushes out_valid pipeline, goes to IDLE. No done pulse.
- Simultaneous events:
  - abort wins over state progress and over timeout.
  - start while busy is ignored.
  - start and abort in IDLE: start is accepted.
  - Sample-count match and timeout in the same cycle: count match wins, no timeout.
- Counters saturate-free: the sample counter is CNT_W bits, and terminal compare prevents wrap.

Test Plan:
1. reset; start with divnum=4, acqnum=8, n_acqclk toggled every 10 cycles, rd_ready=1. Required response: n_load 1-cycle pulse, n_en high until 8th edge, n_rd_rst low 2 cycles, exactly 8 n_rd_en, 8 out_valid words matching injected n_dataout in order, single done pulse, timeout=0.
2. acqnum=5, rd_ready toggled 1/0 each cycle. Required response: n_rd_en only when rd_ready=1, exactly 5 reads, done only after last out_valid.
3. acqnum=3, n_acqclk held low, TMO_CYC reduced to 64. Required response: n_en drops 64 cycles after entering ACQ, timeout=1, done pulse, no n_rd_en.
4. cfg_acqnum=0, then cfg_divnum=0. Required response for each: cfg_err=1, done within 2 cycles of start, n_load and n_en never asserted.
5. abort during ACQ after 2 edges and again during READ after 1 word. Required response: next cycle n_en=0, n_rd_en=0, busy=0, no done. A following start runs cleanly.
6. reset asserted mid-READ; start pulsed while busy. Required response: all outputs at reset values next edge. Busy-time start has no effect on the latched n_divnum/n_acqnum.
